// File: rtl/classify_argmax.sv
// Argmax over a captured logit vector: serial scan, one channel per cycle,
// reporting winning index, its score and the margin over the runner-up.
module classify_argmax #(
  parameter int NO_CH   = 24,
  parameter int BW      = 16,
  parameter int LOG2_CH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_in,
  input  logic [NO_CH*BW-1:0]   data_in,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [LOG2_CH-1:0]    class_out,
  output logic [BW-1:0]         score_out,
  output logic [BW:0]           margin_out,
  output logic                  busy,
  output logic [15:0]           drop_cnt
);

  // ptr runs one past the last channel: that extra step loads the outputs
  localparam int PW = $clog2(NO_CH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t                      r_state, w_nxt;
  logic [NO_CH-1:0][BW-1:0]    r_buf;
  logic signed [BW-1:0]        r_best, r_second, w_c;
  logic [LOG2_CH-1:0]          r_idx;
  logic [PW-1:0]               r_ptr;
  logic                        w_accept, w_drop, w_last;
  logic [BW:0]                 w_margin;

  assign w_accept = vld_in & ((r_state == IDLE) | ((r_state == HOLD) & out_rdy));
  assign w_drop   = vld_in & ~w_accept;
  assign w_last   = (r_ptr == PW'(NO_CH));
  assign w_margin = {r_best[BW-1], r_best} - {r_second[BW-1], r_second};

  assign busy    = (r_state == SCAN) | (r_state == HOLD);
  assign out_vld = (r_state == HOLD);

  always_comb begin
    w_c = r_buf[0];
    for (int i = 1; i < NO_CH; i++)
      if (r_ptr == PW'(i)) w_c = r_buf[i];
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (vld_in) w_nxt = SCAN;
      SCAN: if (w_last) w_nxt = HOLD;
      HOLD: if (out_rdy) w_nxt = vld_in ? SCAN : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_buf      <= '0;
      r_best     <= '0;
      r_second   <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      class_out  <= '0;
      score_out  <= '0;
      margin_out <= '0;
      drop_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_buf    <= data_in;
        r_best   <= data_in[BW-1:0];
        r_second <= {1'b1, {(BW-1){1'b0}}};
        r_idx    <= '0;
        r_ptr    <= PW'(1);
      end else if (r_state == SCAN) begin
        if (w_last) begin
          class_out  <= r_idx;
          score_out  <= r_best;
          margin_out <= w_margin;
        end else begin
          // strict compares: lower index keeps ties, equal value becomes runner-up
          if (w_c > r_best) begin
            r_second <= r_best;
            r_best   <= w_c;
            r_idx    <= LOG2_CH'(r_ptr);
          end else if (w_c > r_second) begin
            r_second <= w_c;
          end
          r_ptr <= r_ptr + PW'(1);
        end
      end
      if (w_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
